hamming_acc_seq: RTL
====================

Name: hamming_acc_seq

Overview:
Sequential Hamming-distance accumulator, parametrised successor of the 1-bit-per-cycle serial counter.
- Consumes W bits of x and y per accepted beat over a frame of N total bits.
- Adds popcount(x^y) to a registered count and signals completion after the last beat.
- Sits as a garbled-circuit benchmark core: a frame controller feeds beats; the host samples o when done is high.

Parameters:
- W, 8, bits of x/y consumed per beat (1..64).
- N, 1600, total bits per frame (N >= 1); BEATS = ceil(N/W).
- CNT_W, $clog2(N+1), width of o (derived, not overridden); N=1600 gives 11.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: clear count and begin a frame.
- in_valid  in  1  x/y beat valid.
- x  in  W  operand A beat.
- y  in  W  operand B beat.
- in_ready  out  1  high in RUN; beat accepted when in_valid && in_ready.
- o  out  CNT_W  registered Hamming distance accumulated so far.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; o is final.

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk. It has priority over all inputs.
  - On reset: state=IDLE, o=0, beat_cnt=0, busy=0, done=0, in_ready=0.
- FSM states: IDLE, RUN, DONE. in_ready=busy=(state==RUN); done=(state==DONE). All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> o<=0, beat_cnt<=0, next RUN.
  - in_valid ignored.
- RUN, on an accepted beat:
  - o <= o + popcount((x^y) & mask); beat_cnt++.
  - mask = all ones except on the last beat when R=N%W != 0; then mask = (1<<R)-1, so only low R bits count.
  - Accepted beat with beat_cnt==BEATS-1 -> next DONE. o holds the final value in the same cycle done rises.
  - Latency: o reflects a beat 1 cycle after acceptance; done rises 1 cycle after the last accepted beat.
  - in_valid=0 -> hold; gaps of any length allowed.
- DONE:
  - o and done hold indefinitely; in_valid ignored.
  - start -> o<=0, beat_cnt<=0, next RUN.
- start in RUN restarts the frame: o<=0, beat_cnt<=0, stay RUN. A simultaneous beat is discarded (start wins).
- Width: popcount is $clog2(W+1) bits, zero-extended to CNT_W. The sum cannot exceed N, so there is no overflow or wrap.
- W=1, N=1600 reproduces the legacy serial count, except o is registered (1-cycle later) and framed.
- beat_cnt width: $clog2(BEATS) (minimum 1). beat_cnt never exceeds BEATS-1.

Optional Feature:
- Macro: HAMMING_THRESH_EN.
- Defined:
  - Adds input thresh [CNT_W-1:0] and output match (1 bit, registered).
  - thresh is sampled at start.
  - match <= (final o <= sampled thresh) on the cycle entering DONE. match is valid while done=1.
  - match is cleared on reset and on start.
- Not defined: no thresh or match ports; logic identical otherwise.

Test Plan:
- W=8, N=16: start, beats (x=0xFF,y=0x00), (x=0x0F,y=0x00) back-to-back -> o=8 then 12; done=1 one cycle after 2nd beat; o holds 12 for 10 idle cycles.
- W=8, N=20: beats 0x00/0x00, 0xAA/0x55, 0xFF/0x00 -> last beat masked to 4 bits; o=0,8,12; done=1.
- W=8, N=16 with in_valid gaps of 3 cycles between beats and x=0x01,y=0x00 -> o=1 then 2; done only after the 2nd accepted beat; busy=1 throughout.
- Start pulsed in RUN after one beat (o=5), same cycle as a beat with distance 3 -> o=0, beat discarded; the new frame then completes normally.
- rst asserted mid-frame (o=7) -> next cycle o=0, busy=0, done=0, in_ready=0; beats ignored until start.
- HAMMING_THRESH_EN, W=8, N=16, thresh=10: frame with distance 12 -> match=0; rerun with distance 10 -> match=1.

Source files
------------

// File: rtl/hamming_acc_seq.sv
// hamming_acc_seq: framed W-bit-per-beat Hamming distance accumulator (optional HAMMING_THRESH_EN adds thresh/match)
module hamming_acc_seq #(
  parameter int W = 8,
  parameter int N = 1600,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
`ifdef HAMMING_THRESH_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             match,
`endif
  output logic             in_ready,
  output logic [CNT_W-1:0] o,
  output logic             busy,
  output logic             done
);
  localparam int BEATS = (N + W - 1) / W;
  localparam int R = N % W;
  localparam int PC_W = $clog2(W + 1);
  localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [W-1:0] LAST_MASK = (R == 0) ? {W{1'b1}} : W'((64'd1 << R) - 64'd1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] o_q, o_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [W-1:0] diff;
  logic [PC_W-1:0] pc;
  logic last, accept;
  assign last = bc_q == BC_W'(BEATS - 1);
  assign accept = (state_q == RUN) && in_valid;
  assign diff = (x ^ y) & (last ? LAST_MASK : {W{1'b1}});
  // population count of the masked difference bits of the current beat
  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) pc = pc + PC_W'(diff[i]);
  end
  // next state: start always wins, otherwise accumulate accepted beats
  always_comb begin
    state_d = state_q;
    o_d = o_q;
    bc_d = bc_q;
    if (start) begin
      state_d = RUN;
      o_d = '0;
      bc_d = '0;
    end else if (accept) begin
      o_d = o_q + CNT_W'(pc);
      bc_d = last ? '0 : bc_q + BC_W'(1);
      state_d = last ? DONE : RUN;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q <= '0;
      bc_q <= '0;
    end else begin
      state_q <= state_d;
      o_q <= o_d;
      bc_q <= bc_d;
    end
  end
`ifdef HAMMING_THRESH_EN
  logic [CNT_W-1:0] thresh_q;
  logic match_q;
  // threshold captured at start; match evaluated on the final count entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_q <= '0;
      match_q <= 1'b0;
    end else if (start) begin
      thresh_q <= thresh;
      match_q <= 1'b0;
    end else if (accept && last) begin
      match_q <= o_d <= thresh_q;
    end
  end
  assign match = match_q;
`endif
  assign o = o_q;
  assign busy = state_q == RUN;
  assign in_ready = state_q == RUN;
  assign done = state_q == DONE;
endmodule
